// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, issuer state encoding and default widths for the ALU command issuer
package alu_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_OP_W   = 5;
   localparam int unsigned DEF_TAG_W  = 4;
   localparam int unsigned DEF_DEPTH  = 4;

   localparam int unsigned OP_ADD  = 0;
   localparam int unsigned OP_SUB  = 1;
   localparam int unsigned OP_AND  = 2;
   localparam int unsigned OP_OR   = 3;
   localparam int unsigned OP_NOT  = 4;
   localparam int unsigned OP_SHL  = 5;
   localparam int unsigned OP_SHR  = 6;
   localparam int unsigned OP_LAST = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } issuer_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with wrap-bit pointers and async active-low reset
module alu_cmd_fifo #(
   parameter int WIDTH = 78,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             do_push, do_pop;

   // Same index with opposite wrap bits means the write side has lapped the read side.
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - buffers tagged ALU commands, issues them to a shared ALU and returns results in order
// Optional ALU_OVF_EN adds rsp_overflow (signed overflow of add/sub).
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int OP_W   = DEF_OP_W,
   parameter int TAG_W  = DEF_TAG_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [TAG_W-1:0]  cmd_tag,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_opcode,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_negative,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_negative,
   output logic [TAG_W-1:0]  rsp_tag,
`ifdef ALU_OVF_EN
   output logic              rsp_overflow,
`endif
   output logic              rsp_illegal
);

   localparam int ENTRY_W = 2*DATA_W + OP_W + TAG_W;
   localparam logic [OP_W-1:0] OP_LAST_W = OP_W'(OP_LAST);

   issuer_state_e     state_q;
   logic [DATA_W-1:0] alu_a_q, alu_b_q;
   logic [OP_W-1:0]   alu_opcode_q;
   logic              rsp_valid_q, rsp_zero_q, rsp_negative_q, rsp_illegal_q;
   logic [DATA_W-1:0] rsp_result_q;
   logic [TAG_W-1:0]  rsp_tag_q;

   logic               fifo_full, fifo_empty, fifo_pop, can_issue, head_legal;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic [DATA_W-1:0]  head_a, head_b;
   logic [OP_W-1:0]    head_op;
   logic [TAG_W-1:0]   head_tag;

   alu_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (cmd_valid),
      .wdata_i ({cmd_a, cmd_b, cmd_op, cmd_tag}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign cmd_ready = !fifo_full;
   assign {head_a, head_b, head_op, head_tag} = fifo_rdata;
   assign head_legal = (head_op <= OP_LAST_W);

   // Issue from IDLE, or straight out of RESP as the response is taken so there is no bubble.
   always_comb begin
      can_issue = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
      fifo_pop  = can_issue && !fifo_empty;
   end

`ifdef ALU_OVF_EN
   logic rsp_overflow_q;
   logic ovf_calc;

   always_comb begin
      ovf_calc = 1'b0;
      if (alu_opcode_q == OP_W'(OP_ADD))
         ovf_calc = (alu_a_q[DATA_W-1] == alu_b_q[DATA_W-1]) &&
                    (alu_result[DATA_W-1] != alu_a_q[DATA_W-1]);
      else if (alu_opcode_q == OP_W'(OP_SUB))
         ovf_calc = (alu_a_q[DATA_W-1] != alu_b_q[DATA_W-1]) &&
                    (alu_result[DATA_W-1] != alu_a_q[DATA_W-1]);
   end

   assign rsp_overflow = rsp_overflow_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         alu_opcode_q   <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_result_q   <= '0;
         rsp_zero_q     <= 1'b0;
         rsp_negative_q <= 1'b0;
         rsp_illegal_q  <= 1'b0;
         rsp_tag_q      <= '0;
`ifdef ALU_OVF_EN
         rsp_overflow_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_WAIT: begin
               rsp_result_q   <= alu_result;
               rsp_zero_q     <= alu_zero;
               rsp_negative_q <= alu_negative;
               rsp_illegal_q  <= 1'b0;
               rsp_valid_q    <= 1'b1;
`ifdef ALU_OVF_EN
               rsp_overflow_q <= ovf_calc;
`endif
               state_q        <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: ;
         endcase

         // A pop overrides the defaults above with the decision for the new head entry.
         if (fifo_pop) begin
            rsp_tag_q <= head_tag;
            if (head_legal) begin
               alu_a_q      <= head_a;
               alu_b_q      <= head_b;
               alu_opcode_q <= head_op;
               state_q      <= S_WAIT;
            end else begin
               rsp_result_q   <= '0;
               rsp_zero_q     <= 1'b1;
               rsp_negative_q <= 1'b0;
               rsp_illegal_q  <= 1'b1;
               rsp_valid_q    <= 1'b1;
`ifdef ALU_OVF_EN
               rsp_overflow_q <= 1'b0;
`endif
               state_q        <= S_RESP;
            end
         end
      end
   end

   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_opcode   = alu_opcode_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_zero     = rsp_zero_q;
   assign rsp_negative = rsp_negative_q;
   assign rsp_illegal  = rsp_illegal_q;
   assign rsp_tag      = rsp_tag_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - directed self-checking bench for alu_cmd_issuer with a behavioural ALU
module tb_alu_cmd_issuer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_a, cmd_b;
   logic [4:0]  cmd_op;
   logic [3:0]  cmd_tag;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [4:0]  alu_opcode;
   logic        alu_zero, alu_negative;
   logic        rsp_valid, rsp_ready, rsp_zero, rsp_negative, rsp_illegal;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_tag;
`ifdef ALU_OVF_EN
   logic        rsp_overflow;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_res  [0:7];
   logic [3:0]  exp_tag  [0:7];
   logic        exp_zero [0:7];
   logic        exp_neg  [0:7];
   logic        exp_ovf  [0:7];

   always #5 clk = ~clk;

   alu_cmd_issuer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_op       (cmd_op),
      .cmd_tag      (cmd_tag),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_opcode   (alu_opcode),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .alu_negative (alu_negative),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .rsp_negative (rsp_negative),
      .rsp_tag      (rsp_tag),
`ifdef ALU_OVF_EN
      .rsp_overflow (rsp_overflow),
`endif
      .rsp_illegal  (rsp_illegal)
   );

   // Combinational ALU the issuer drives.
   always_comb begin
      case (alu_opcode)
         5'd0:    alu_result = alu_a + alu_b;
         5'd1:    alu_result = alu_a - alu_b;
         5'd2:    alu_result = alu_a & alu_b;
         5'd3:    alu_result = alu_a | alu_b;
         5'd4:    alu_result = ~alu_a;
         5'd5:    alu_result = alu_a << alu_b[4:0];
         5'd6:    alu_result = alu_a >> alu_b[4:0];
         default: alu_result = 32'd0;
      endcase
      alu_zero     = (alu_result == 32'd0);
      alu_negative = alu_result[31];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                       input logic [3:0] tag);
      int wait_cyc = 0;
      cmd_valid = 1'b1;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
      while (!cmd_ready && wait_cyc < 50) begin
         step();
         wait_cyc++;
      end
      if (wait_cyc >= 50) check("push_timeout", 32'(wait_cyc), 32'd0);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic collect(input int n, input int max_cyc);
      int got = 0, cyc = 0, last = -1;
      while (got < n && cyc < max_cyc) begin
         if (rsp_valid && rsp_ready) begin
            check($sformatf("rsp%0d_result", got), rsp_result, exp_res[got]);
            check($sformatf("rsp%0d_tag", got), 32'(rsp_tag), 32'(exp_tag[got]));
            check($sformatf("rsp%0d_zero", got), 32'(rsp_zero), 32'(exp_zero[got]));
            check($sformatf("rsp%0d_neg", got), 32'(rsp_negative), 32'(exp_neg[got]));
            check($sformatf("rsp%0d_illegal", got), 32'(rsp_illegal), 32'd0);
`ifdef ALU_OVF_EN
            check($sformatf("rsp%0d_ovf", got), 32'(rsp_overflow), 32'(exp_ovf[got]));
`endif
            if (last >= 0) check($sformatf("rsp%0d_gap", got), 32'(cyc - last), 32'd2);
            last = cyc;
            got++;
         end
         step();
         cyc++;
      end
      check("rsp_count", 32'(got), 32'(n));
   endtask

   task automatic set_exp(input int i, input logic [31:0] r, input logic [3:0] t,
                          input logic z, input logic ng, input logic ov);
      exp_res[i] = r; exp_tag[i] = t; exp_zero[i] = z; exp_neg[i] = ng; exp_ovf[i] = ov;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int valid_seen;
      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
      repeat (3) step();

      check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_alu_a", alu_a, 32'd0);
      check("reset_alu_opcode", 32'(alu_opcode), 32'd0);
      check("reset_rsp_zero", 32'(rsp_zero), 32'd0);
      check("reset_rsp_illegal", 32'(rsp_illegal), 32'd0);
      check("reset_rsp_tag", 32'(rsp_tag), 32'd0);
      rst_n = 1'b1;
      step();

      // Single add: issue at E1, response at E2.
      rsp_ready = 1'b1;
      push(32'd10, 32'd20, 5'd0, 4'd3);
      check("add_e0_valid", 32'(rsp_valid), 32'd0);
      step();
      check("add_alu_a", alu_a, 32'd10);
      check("add_alu_b", alu_b, 32'd20);
      check("add_alu_op", 32'(alu_opcode), 32'd0);
      check("add_e1_valid", 32'(rsp_valid), 32'd0);
      step();
      check("add_e2_valid", 32'(rsp_valid), 32'd1);
      check("add_result", rsp_result, 32'd30);
      check("add_zero", 32'(rsp_zero), 32'd0);
      check("add_neg", 32'(rsp_negative), 32'd0);
      check("add_tag", 32'(rsp_tag), 32'd3);
      step();
      check("add_consumed", 32'(rsp_valid), 32'd0);

      // Back-to-back legal commands, one response every 2 cycles.
      set_exp(0, 32'hFFFFFFF6, 4'd1, 1'b0, 1'b1, 1'b0);
      set_exp(1, 32'hFFFFFFF5, 4'd2, 1'b0, 1'b1, 1'b0);
      set_exp(2, 32'd40,       4'd3, 1'b0, 1'b0, 1'b0);
      set_exp(3, 32'd2,        4'd4, 1'b0, 1'b0, 1'b0);
      fork
         begin
            push(32'd10, 32'd20, 5'd1, 4'd1);
            push(32'd10, 32'd0,  5'd4, 4'd2);
            push(32'd10, 32'd2,  5'd5, 4'd3);
            push(32'd10, 32'd2,  5'd6, 4'd4);
         end
         collect(4, 40);
      join
      repeat (3) step();

      // Backpressure: one in flight plus four buffered fills the FIFO.
      rsp_ready = 1'b0;
      push(32'd1,    32'd2,    5'd0, 4'd5);
      push(32'd5,    32'd5,    5'd1, 4'd6);
      push(32'hF0,   32'h3C,   5'd2, 4'd8);
      push(32'hF0,   32'h0F,   5'd3, 4'd9);
      push(32'd1,    32'd31,   5'd5, 4'd10);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      cmd_valid = 1'b1; cmd_a = 32'd99; cmd_b = 32'd1; cmd_op = 5'd0; cmd_tag = 4'd15;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("bp_hold%0d_result", i), rsp_result, 32'd3);
         check($sformatf("bp_hold%0d_tag", i), 32'(rsp_tag), 32'd5);
         check($sformatf("bp_hold%0d_ready", i), 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      set_exp(0, 32'd3,        4'd5,  1'b0, 1'b0, 1'b0);
      set_exp(1, 32'd0,        4'd6,  1'b1, 1'b0, 1'b0);
      set_exp(2, 32'h30,       4'd8,  1'b0, 1'b0, 1'b0);
      set_exp(3, 32'hFF,       4'd9,  1'b0, 1'b0, 1'b0);
      set_exp(4, 32'h80000000, 4'd10, 1'b0, 1'b1, 1'b0);
      rsp_ready = 1'b1;
      collect(5, 40);
      valid_seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) valid_seen++;
         step();
      end
      check("bp_no_extra_rsp", 32'(valid_seen), 32'd0);

      // Illegal opcode: response one cycle after issue, ALU operands untouched.
      rsp_ready = 1'b0;
      push(32'h55, 32'h66, 5'd9, 4'd7);
      check("ill_e0_valid", 32'(rsp_valid), 32'd0);
      step();
      check("ill_e1_valid", 32'(rsp_valid), 32'd1);
      check("ill_result", rsp_result, 32'd0);
      check("ill_zero", 32'(rsp_zero), 32'd1);
      check("ill_neg", 32'(rsp_negative), 32'd0);
      check("ill_flag", 32'(rsp_illegal), 32'd1);
      check("ill_tag", 32'(rsp_tag), 32'd7);
      check("ill_alu_op", 32'(alu_opcode), 32'd5);
      check("ill_alu_a", alu_a, 32'd1);
      rsp_ready = 1'b1;
      step();
      check("ill_consumed", 32'(rsp_valid), 32'd0);

`ifdef ALU_OVF_EN
      set_exp(0, 32'h80000000, 4'd1, 1'b0, 1'b1, 1'b1);
      set_exp(1, 32'h7FFFFFFF, 4'd2, 1'b0, 1'b0, 1'b1);
      set_exp(2, 32'd0,        4'd3, 1'b1, 1'b0, 1'b0);
      fork
         begin
            push(32'h7FFFFFFF, 32'd1, 5'd0, 4'd1);
            push(32'h80000000, 32'd1, 5'd1, 4'd2);
            push(32'd10,       32'd20, 5'd2, 4'd3);
         end
         collect(3, 40);
      join
      repeat (3) step();
`endif

      // Reset while in WAIT with two commands queued.
      rsp_ready = 1'b0;
      push(32'd1, 32'd1, 5'd0, 4'd1);
      push(32'd2, 32'd2, 5'd0, 4'd2);
      push(32'd3, 32'd3, 5'd0, 4'd3);
      push(32'd4, 32'd4, 5'd0, 4'd4);
      check("rst_pre_valid", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("rst_in_wait", 32'(rsp_valid), 32'd0);
      check("rst_pre_alu_a", alu_a, 32'd2);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_mid_alu_a", alu_a, 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      valid_seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (rsp_valid) valid_seen++;
      end
      check("rst_no_stale_rsp", 32'(valid_seen), 32'd0);
      check("rst_post_cmd_ready", 32'(cmd_ready), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
